// File: rtl/ascii_field_decoder_pkg.sv
// Shared character constants, digit test and decoder state encoding for ascii_field_decoder.
// Optional signed-field support is selected with ASCII_FIELD_DECODER_SIGNED_EN.
package ascii_pkg;

  localparam logic [7:0] CH_NUL   = 8'h00;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_NINE  = 8'h39;

  typedef enum logic [1:0] {
    ST_SEEK,
    ST_NUMBER,
    ST_DONE
  } dec_state_e;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_ZERO) && (c <= CH_NINE);
  endfunction

endpackage

// File: rtl/ascii_field_decoder_decimal_accumulator.sv
// Decimal digit accumulator for one field: builds the value digit by digit and flags range overflow.
// With ASCII_FIELD_DECODER_SIGNED_EN the magnitude is negated on output and checked against the signed range.
module decimal_accumulator #(
  parameter int FIELD_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   start,
  input  logic                   digit,
  input  logic [3:0]             digit_value,
`ifdef ASCII_FIELD_DECODER_SIGNED_EN
  input  logic                   negative,
`endif
  output logic [FIELD_WIDTH-1:0] value,
  output logic                   overflow
);

  localparam int WIDE_W = FIELD_WIDTH + 4;

  logic [FIELD_WIDTH-1:0] mag_q, mag_d;
  logic                   carry_q, carry_d;
  logic [WIDE_W-1:0]      next_wide;

`ifdef ASCII_FIELD_DECODER_SIGNED_EN
  localparam logic [FIELD_WIDTH-1:0] HALF_RANGE = {1'b1, {(FIELD_WIDTH-1){1'b0}}};
  logic neg_q, neg_d;
`endif

  // Four spare bits hold acc*10+9 exactly, so anything above FIELD_WIDTH is a true carry out.
  always_comb begin
    next_wide = ({4'b0000, mag_q} * WIDE_W'(10)) + WIDE_W'(digit_value);
    mag_d     = mag_q;
    carry_d   = carry_q;
`ifdef ASCII_FIELD_DECODER_SIGNED_EN
    neg_d     = neg_q;
`endif
    if (clear) begin
      mag_d   = '0;
      carry_d = 1'b0;
`ifdef ASCII_FIELD_DECODER_SIGNED_EN
      neg_d   = 1'b0;
`endif
    end else if (start) begin
      mag_d   = FIELD_WIDTH'(digit_value);
      carry_d = 1'b0;
`ifdef ASCII_FIELD_DECODER_SIGNED_EN
      neg_d   = negative;
`endif
    end else if (digit) begin
      mag_d   = next_wide[FIELD_WIDTH-1:0];
      carry_d = carry_q | (next_wide[WIDE_W-1:FIELD_WIDTH] != 4'b0000);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mag_q   <= '0;
      carry_q <= 1'b0;
`ifdef ASCII_FIELD_DECODER_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      mag_q   <= mag_d;
      carry_q <= carry_d;
`ifdef ASCII_FIELD_DECODER_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

`ifdef ASCII_FIELD_DECODER_SIGNED_EN
  assign value    = neg_q ? (~mag_q + FIELD_WIDTH'(1)) : mag_q;
  assign overflow = carry_q | (neg_q ? (mag_q > HALF_RANGE) : (mag_q >= HALF_RANGE));
`else
  assign value    = mag_q;
  assign overflow = carry_q;
`endif

endmodule

// File: rtl/ascii_field_decoder.sv
// Line-oriented ASCII decimal field decoder: one record per LF, EOF on two NULs, output backpressure.
// Define ASCII_FIELD_DECODER_SIGNED_EN to accept '-' prefixed two's complement fields.
module ascii_field_decoder
  import ascii_pkg::*;
#(
  parameter int INBOUND_DATA_WIDTH = 8,
  parameter int FIELD_COUNT        = 4,
  parameter int FIELD_WIDTH        = 12
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 inbound_valid,
  output logic                                 inbound_ready,
  input  logic [INBOUND_DATA_WIDTH-1:0]        inbound_data,
  output logic                                 record_valid,
  input  logic                                 record_ready,
  output logic [FIELD_COUNT*FIELD_WIDTH-1:0]   record_fields,
  output logic [$clog2(FIELD_COUNT+1)-1:0]     record_count,
  output logic                                 record_overflow,
  output logic                                 record_extra,
  output logic                                 end_of_file
);

  localparam int              CNT_W      = $clog2(FIELD_COUNT + 1);
  localparam logic [CNT_W-1:0] FULL_INDEX = CNT_W'(FIELD_COUNT);

  dec_state_e state_q, state_d;

  logic [FIELD_WIDTH-1:0] fields_q [FIELD_COUNT];
  logic [FIELD_WIDTH-1:0] fields_d [FIELD_COUNT];
  logic [FIELD_WIDTH-1:0] fields_c [FIELD_COUNT];
  logic [CNT_W-1:0]       index_q, index_d, index_c;
  logic                   line_ovf_q, line_ovf_d, ovf_c;
  logic                   line_extra_q, line_extra_d, extra_c;
  logic                   nul_q, nul_d;

  logic                               rec_valid_q, rec_valid_d;
  logic [FIELD_COUNT*FIELD_WIDTH-1:0] rec_fields_q, rec_fields_d, fields_flat;
  logic [CNT_W-1:0]                   rec_count_q, rec_count_d;
  logic                               rec_ovf_q, rec_ovf_d;
  logic                               rec_extra_q, rec_extra_d;
  logic                               eof_q, eof_d;

  logic [7:0]             ch;
  logic                   accept, ch_digit, ch_lf, ch_nul, commit, line_end, emit;
  logic                   acc_start, acc_digit, acc_clear, acc_overflow;
  logic [FIELD_WIDTH-1:0] acc_value;

`ifdef ASCII_FIELD_DECODER_SIGNED_EN
  logic minus_q, minus_d;
`endif

  assign ch            = inbound_data[7:0];
  assign inbound_ready = !rec_valid_q || record_ready;
  assign accept        = inbound_valid && inbound_ready;
  assign ch_digit      = is_digit(ch);
  assign ch_lf         = (ch == CH_LF);
  assign ch_nul        = (ch == CH_NUL);
  assign commit        = accept && (state_q == ST_NUMBER) && !ch_digit;
  assign line_end      = ch_lf || (ch_nul && nul_q);
  assign emit          = ch_lf || (index_c != '0);

  decimal_accumulator #(
    .FIELD_WIDTH (FIELD_WIDTH)
  ) u_accumulator (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (acc_clear),
    .start       (acc_start),
    .digit       (acc_digit),
    .digit_value (ch[3:0]),
`ifdef ASCII_FIELD_DECODER_SIGNED_EN
    .negative    (minus_q),
`endif
    .value       (acc_value),
    .overflow    (acc_overflow)
  );

  // Line state as it stands after committing the number this byte terminates (if any).
  always_comb begin
    fields_c = fields_q;
    index_c  = index_q;
    ovf_c    = line_ovf_q;
    extra_c  = line_extra_q;
    if (commit) begin
      ovf_c = line_ovf_q | acc_overflow;
      if (index_q < FULL_INDEX) begin
        for (int i = 0; i < FIELD_COUNT; i++) begin
          if (index_q == CNT_W'(i)) fields_c[i] = acc_value;
        end
        index_c = index_q + CNT_W'(1);
      end else begin
        extra_c = 1'b1;
      end
    end
  end

  always_comb begin
    fields_flat = '0;
    for (int i = 0; i < FIELD_COUNT; i++) begin
      fields_flat[(FIELD_COUNT-1-i)*FIELD_WIDTH +: FIELD_WIDTH] = fields_c[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    fields_d     = fields_q;
    index_d      = index_q;
    line_ovf_d   = line_ovf_q;
    line_extra_d = line_extra_q;
    nul_d        = nul_q;
    rec_valid_d  = rec_valid_q && !record_ready;
    rec_fields_d = rec_fields_q;
    rec_count_d  = rec_count_q;
    rec_ovf_d    = rec_ovf_q;
    rec_extra_d  = rec_extra_q;
    eof_d        = eof_q || ((state_q == ST_DONE) && (!rec_valid_q || record_ready));
    acc_start    = 1'b0;
    acc_digit    = 1'b0;
    acc_clear    = 1'b0;
`ifdef ASCII_FIELD_DECODER_SIGNED_EN
    minus_d      = minus_q;
`endif
    if (accept && (state_q != ST_DONE)) begin
      nul_d        = ch_nul;
      fields_d     = fields_c;
      index_d      = index_c;
      line_ovf_d   = ovf_c;
      line_extra_d = extra_c;
`ifdef ASCII_FIELD_DECODER_SIGNED_EN
      minus_d      = (ch == CH_MINUS);
`endif
      if (ch_digit) begin
        state_d = ST_NUMBER;
        if (state_q == ST_SEEK) acc_start = 1'b1;
        else                    acc_digit = 1'b1;
      end else begin
        state_d = ST_SEEK;
      end
      // An EOF with nothing pending ends the stream without an empty record.
      if (line_end) begin
        fields_d     = '{default: '0};
        index_d      = '0;
        line_ovf_d   = 1'b0;
        line_extra_d = 1'b0;
        acc_clear    = 1'b1;
        if (emit) begin
          rec_valid_d  = 1'b1;
          rec_fields_d = fields_flat;
          rec_count_d  = index_c;
          rec_ovf_d    = ovf_c;
          rec_extra_d  = extra_c;
        end
        if (ch_nul) state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_SEEK;
      fields_q     <= '{default: '0};
      index_q      <= '0;
      line_ovf_q   <= 1'b0;
      line_extra_q <= 1'b0;
      nul_q        <= 1'b0;
      rec_valid_q  <= 1'b0;
      rec_fields_q <= '0;
      rec_count_q  <= '0;
      rec_ovf_q    <= 1'b0;
      rec_extra_q  <= 1'b0;
      eof_q        <= 1'b0;
`ifdef ASCII_FIELD_DECODER_SIGNED_EN
      minus_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fields_q     <= fields_d;
      index_q      <= index_d;
      line_ovf_q   <= line_ovf_d;
      line_extra_q <= line_extra_d;
      nul_q        <= nul_d;
      rec_valid_q  <= rec_valid_d;
      rec_fields_q <= rec_fields_d;
      rec_count_q  <= rec_count_d;
      rec_ovf_q    <= rec_ovf_d;
      rec_extra_q  <= rec_extra_d;
      eof_q        <= eof_d;
`ifdef ASCII_FIELD_DECODER_SIGNED_EN
      minus_q      <= minus_d;
`endif
    end
  end

  assign record_valid    = rec_valid_q;
  assign record_fields   = rec_fields_q;
  assign record_count    = rec_count_q;
  assign record_overflow = rec_ovf_q;
  assign record_extra    = rec_extra_q;
  assign end_of_file     = eof_q;

endmodule

// File: tb/tb_ascii_field_decoder.sv
// Self-checking bench for ascii_field_decoder: table of lines with expected records, scoreboard
// queue checked on every record handshake, plus stall, mid-line reset and EOF sequences.
module tb_ascii_field_decoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        inbound_valid = 1'b0;
  logic        inbound_ready;
  logic [7:0]  inbound_data = 8'h00;
  logic        record_valid;
  logic        record_ready = 1'b1;
  logic [47:0] record_fields;
  logic [2:0]  record_count;
  logic        record_overflow;
  logic        record_extra;
  logic        end_of_file;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string       text;
    logic [47:0] fields;
    logic [2:0]  count;
    logic        ovf;
    logic        extra;
  } vec_t;

  typedef struct {
    logic [47:0] fields;
    logic [2:0]  count;
    logic        ovf;
    logic        extra;
  } rec_t;

  vec_t vecs[$];
  rec_t expected_q[$];
  rec_t mon_exp;
  int   waited;

  ascii_field_decoder #(
    .INBOUND_DATA_WIDTH (8),
    .FIELD_COUNT        (4),
    .FIELD_WIDTH        (12)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .inbound_valid   (inbound_valid),
    .inbound_ready   (inbound_ready),
    .inbound_data    (inbound_data),
    .record_valid    (record_valid),
    .record_ready    (record_ready),
    .record_fields   (record_fields),
    .record_count    (record_count),
    .record_overflow (record_overflow),
    .record_extra    (record_extra),
    .end_of_file     (end_of_file)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [47:0] actual, input logic [47:0] required);
    tests_run++;
    if (actual !== required) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  // Called at a falling edge; holds the byte until the DUT takes it on a rising edge.
  task automatic send_byte(input logic [7:0] b);
    logic ok;
    inbound_data  = b;
    inbound_valid = 1'b1;
    for (int guard = 0; guard < 200; guard++) begin
      #4;
      ok = inbound_ready;
      @(negedge clk);
      if (ok) begin
        inbound_valid = 1'b0;
        return;
      end
    end
    inbound_valid = 1'b0;
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL byte_accept_timeout: got no accept for 0x%0h, expected accept within 200 cycles", b);
  endtask

  task automatic apply_stimulus(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic expect_record(input logic [47:0] f, input logic [2:0] c, input logic o, input logic e);
    rec_t r;
    r.fields = f; r.count = c; r.ovf = o; r.extra = e;
    expected_q.push_back(r);
  endtask

  // Scoreboard: every handshake pops the oldest expected record.
  always @(negedge clk) begin
    #1;
    if (reset_n && record_valid && record_ready) begin
      if (expected_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_record: got fields 0x%0h, expected no record", record_fields);
      end else begin
        mon_exp = expected_q.pop_front();
        check_output("record_fields", record_fields, mon_exp.fields);
        check_output("record_count", 48'(record_count), 48'(mon_exp.count));
        check_output("record_overflow", 48'(record_overflow), 48'(mon_exp.ovf));
        check_output("record_extra", 48'(record_extra), 48'(mon_exp.extra));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 500000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs.push_back('{"turn on 0,0 through 999,999\n", {12'd0, 12'd0, 12'd999, 12'd999}, 3'd4, 1'b0, 1'b0});
    vecs.push_back('{"5000,1\n", {12'd904, 12'd1, 12'd0, 12'd0}, 3'd2, 1'b1, 1'b0});
    vecs.push_back('{"1,2,3,4,5\n", {12'd1, 12'd2, 12'd3, 12'd4}, 3'd4, 1'b0, 1'b1});
    vecs.push_back('{"6\n", {12'd6, 12'd0, 12'd0, 12'd0}, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{"a1b22c333 44\n", {12'd1, 12'd22, 12'd333, 12'd44}, 3'd4, 1'b0, 1'b0});
    vecs.push_back('{"\n", 48'd0, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{"10 20 30 40 50 60\n", {12'd10, 12'd20, 12'd30, 12'd40}, 3'd4, 1'b0, 1'b1});
`ifdef ASCII_FIELD_DECODER_SIGNED_EN
    vecs.push_back('{"-12,3\n", {12'hFF4, 12'd3, 12'd0, 12'd0}, 3'd2, 1'b0, 1'b0});
    vecs.push_back('{"-2048 2047\n", {12'h800, 12'h7FF, 12'd0, 12'd0}, 3'd2, 1'b0, 1'b0});
    vecs.push_back('{"2048\n", {12'h800, 12'd0, 12'd0, 12'd0}, 3'd1, 1'b1, 1'b0});
    vecs.push_back('{"-2049\n", {12'h7FF, 12'd0, 12'd0, 12'd0}, 3'd1, 1'b1, 1'b0});
    vecs.push_back('{"5-x\n", {12'd5, 12'd0, 12'd0, 12'd0}, 3'd1, 1'b0, 1'b0});
`else
    vecs.push_back('{"-12,3\n", {12'd12, 12'd3, 12'd0, 12'd0}, 3'd2, 1'b0, 1'b0});
    vecs.push_back('{"4095,4096\n", {12'd4095, 12'd0, 12'd0, 12'd0}, 3'd2, 1'b1, 1'b0});
`endif

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_record_valid", 48'(record_valid), 48'd0);
    check_output("reset_record_fields", record_fields, 48'd0);
    check_output("reset_record_count", 48'(record_count), 48'd0);
    check_output("reset_record_overflow", 48'(record_overflow), 48'd0);
    check_output("reset_record_extra", 48'(record_extra), 48'd0);
    check_output("reset_end_of_file", 48'(end_of_file), 48'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < vecs.size(); v++) begin
      expect_record(vecs[v].fields, vecs[v].count, vecs[v].ovf, vecs[v].extra);
      apply_stimulus(vecs[v].text.substr(0, vecs[v].text.len() - 2));
      if (vecs[v].text.len() > 1) check_output("valid_before_lf", 48'(record_valid), 48'd0);
      send_byte(8'h0A);
      check_output("valid_after_lf", 48'(record_valid), 48'd1);
    end

    // Output stalled for 10 cycles with a second line queued behind the first record.
    @(negedge clk);
    record_ready = 1'b0;
    expect_record({12'd11, 12'd22, 12'd0, 12'd0}, 3'd2, 1'b0, 1'b0);
    expect_record({12'd33, 12'd0, 12'd0, 12'd0}, 3'd1, 1'b0, 1'b0);
    fork
      begin
        apply_stimulus("11,22\n");
        apply_stimulus("33\n");
      end
      begin
        waited = 0;
        while (!record_valid && waited < 100) begin
          @(negedge clk);
          waited++;
        end
        check_output("stall_record_arrives", 48'(record_valid), 48'd1);
        for (int i = 0; i < 10; i++) begin
          #2;
          check_output("stall_inbound_ready", 48'(inbound_ready), 48'd0);
          check_output("stall_record_count", 48'(record_count), 48'd2);
          @(negedge clk);
        end
        record_ready = 1'b1;
      end
    join
    repeat (2) @(negedge clk);

    // Reset mid-line with a pending NUL: partial fields and the NUL must vanish.
    apply_stimulus("4,5");
    send_byte(8'h00);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_output("midreset_record_valid", 48'(record_valid), 48'd0);
    reset_n = 1'b1;
    @(negedge clk);
    expect_record({12'd9, 12'd0, 12'd0, 12'd0}, 3'd1, 1'b0, 1'b0);
    send_byte(8'h00);
    apply_stimulus("9\n");
    @(negedge clk);
    check_output("midreset_no_eof", 48'(end_of_file), 48'd0);

    // Unterminated final line flushed by two NULs, then sticky end_of_file.
    expect_record({12'd7, 12'd8, 12'd0, 12'd0}, 3'd2, 1'b0, 1'b0);
    apply_stimulus("7 8");
    send_byte(8'h00);
    check_output("eof_no_record_first_nul", 48'(record_valid), 48'd0);
    send_byte(8'h00);
    check_output("eof_flush_valid", 48'(record_valid), 48'd1);
    check_output("eof_low_while_record", 48'(end_of_file), 48'd0);
    @(negedge clk);
    check_output("eof_after_handshake", 48'(end_of_file), 48'd1);
    check_output("eof_record_valid_low", 48'(record_valid), 48'd0);
    apply_stimulus("1\n");
    repeat (3) @(negedge clk);
    check_output("eof_sticky", 48'(end_of_file), 48'd1);
    check_output("done_ignores_bytes", 48'(record_valid), 48'd0);

    repeat (5) @(negedge clk);
    check_output("scoreboard_drained", 48'(expected_q.size()), 48'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ascii_field_decoder.md
# ascii_field_decoder

Generalised successor of the per-puzzle line decoders: consumes the deserialized ASCII byte stream and emits, once per line, a record of up to FIELD_COUNT decimal fields of FIELD_WIDTH bits, with field count and error flags. Sits between the byte deserializer and any puzzle-specific solver core. It adds output backpressure, overflow/extra-field detection and end-of-file flush of an unterminated final line.

## Interface
- INBOUND_DATA_WIDTH, 8: character width.
- FIELD_COUNT, 4: maximum fields captured per line.
- FIELD_WIDTH, 12: bits per field.
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- inbound_valid  in  1  byte present.
- inbound_ready  out  1  byte accepted when valid && ready.
- inbound_data  in  INBOUND_DATA_WIDTH  ASCII byte.
- record_valid  out  1  record held.
- record_ready  in  1  consumer accepts record.
- record_fields  out  FIELD_COUNT*FIELD_WIDTH  field 0 in most significant slice; absent fields zero.
- record_count  out  $clog2(FIELD_COUNT+1)  fields found on the line (saturates at FIELD_COUNT).
- record_overflow  out  1  some field exceeded its range.
- record_extra  out  1  line held more than FIELD_COUNT fields.
- end_of_file  out  1  sticky; stream ended and last record consumed.

## Operation
- Accepted byte = inbound_valid && inbound_ready. inbound_ready = !record_valid || record_ready (combinational).
- States: SEEK (between numbers), NUMBER (digits accumulating), DONE (after EOF). Reset -> SEEK.
- SEEK + digit -> NUMBER, accumulator = digit. NUMBER + digit -> acc = acc*10 + digit, truncated to FIELD_WIDTH; any carry out of FIELD_WIDTH sets line overflow flag (sticky per line). NUMBER + non-digit -> commit acc to slot field_index, index++, -> SEEK.
- Commit when index == FIELD_COUNT: value dropped, line extra flag set, count stays FIELD_COUNT.
- LF ('\n', 0x0A): commits any in-progress number, loads output register (fields, count, flags), clears line state. A line with zero fields still emits a record with count 0.
- All other non-digit bytes (letters, ',', ' ') are separators.
- EOF: two consecutive accepted NUL (0x00) bytes. If fields pending from an unterminated line, they are flushed as a record on the second NUL. -> DONE; further bytes accepted and ignored.
- end_of_file rises once in DONE with record_valid low; stays high until reset.

## Timing
- Reset values: record_valid 0, record_fields 0, record_count 0, record_overflow 0, record_extra 0, end_of_file 0, state SEEK.
- Record latency: record_valid high the cycle after the LF (or second NUL) is accepted.
- Record outputs stable while record_valid && !record_ready; record_valid drops the cycle after handshake unless a new LF is accepted that same cycle (back-to-back allowed).
- A byte is never dropped: while output register full and not draining, inbound_ready is 0 for every byte, including non-LF.
- end_of_file earliest one cycle after final record handshake.
- Reset mid-line: partial fields, flags and pending NUL discarded.

## Configuration
- ASCII_FIELD_DECODER_SIGNED_EN defined: '-' immediately followed by a digit marks the field negative; value stored as two's complement in FIELD_WIDTH; overflow when magnitude exceeds 2^(FIELD_WIDTH-1) (negative) or 2^(FIELD_WIDTH-1)-1 (positive). '-' not followed by a digit is a separator.
- Undefined: '-' is a separator; fields unsigned, overflow above 2^FIELD_WIDTH-1.

## Structure
- Package ascii_pkg: character constants (NUL, LF, SPACE, COMMA, MINUS, ZERO, NINE), is_digit function, decoder state enum.
- Sub-module decimal_accumulator: digit/start/clear inputs, FIELD_WIDTH value and overflow outputs (sign handling inside under the macro).
- Top holds state machine, field slots, output register and handshake.

## Test plan
- "turn on 0,0 through 999,999\n", record_ready=1 -> fields {0,0,999,999}, count 4, overflow 0, extra 0, valid one cycle after LF.
- "5000,1\n" -> field0 = 904 (5000 mod 4096), field1 = 1, count 2, overflow 1.
- "1,2,3,4,5\n" -> fields {1,2,3,4}, count 4, extra 1; next line "6\n" -> {6,0,0,0}, flags clear.
- Two lines back-to-back with record_ready held 0 for 10 cycles -> inbound_ready 0 during stall, both records delivered intact in order.
- "7 8" then NUL NUL -> record {7,8,0,0} count 2; end_of_file 1 after its handshake, stays 1.
- Signed build: "-12,3\n" -> field0 0xFF4, field1 3; reset_n low mid-line "4,5" then "9\n" -> single record {9,0,0,0}.
